modexp: RTL

Left-to-right square-and-multiply modular exponentiation controller: result = base^exp mod n. It is the initiator side of the start/ready multiplier handshake and drives an external `modmul` instance (same W) through a dedicated port group. It sits above `modmul` in the RSA datapath. It holds operands stable for the whole of each multiply.

---
 rtl/modexp_pkg.sv | 18 +
 rtl/modexp_if.sv | 36 +++
 rtl/modmul.sv | 58 +++++
 rtl/modexp.sv | 108 ++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared types and defaults for the modular exponentiation controller.
package modexp_pkg;

   localparam int W_DEF  = 2048;
   localparam int EW_DEF = W_DEF;
   localparam int RW     = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_STEP,
      S_SQR_ISSUE,
      S_SQR_WAIT,
      S_MUL_ISSUE,
      S_MUL_WAIT
   } state_e;

endpackage

// File: rtl/modexp_if.sv
// Host request bus plus the multiplier port group of modexp.
interface modexp_if #(
   parameter int W  = modexp_pkg::W_DEF,
   parameter int EW = W
);
   logic          start;
   logic          ready;
   logic [W-1:0]  base;
   logic [EW-1:0] exp;
   logic [W-1:0]  n;
   logic [W-1:0]  result;

   logic          mm_start;
   logic          mm_ready;
   logic [W-1:0]  mm_a;
   logic [W-1:0]  mm_b;
   logic [W-1:0]  mm_n;
   logic [W-1:0]  mm_p;

   modport master (
      output start, base, exp, n,
      input  ready, result
   );

   modport slave (
      input  start, base, exp, n,
      output ready, result,
      output mm_start, mm_a, mm_b, mm_n,
      input  mm_ready, mm_p
   );

   modport mm (
      input  mm_start, mm_a, mm_b, mm_n,
      output mm_ready, mm_p
   );
endinterface

// File: rtl/modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, one bit of a per cycle,
// ready low for exactly W cycles after an accepted start.
module modmul #(
   parameter int W = modexp_pkg::W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] n_i,
   output logic         ready_o,
   output logic [W-1:0] p_o
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  a_q, b_q, n_q, p_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic [W+1:0]  dbl, red1, sum, red2, nn;

   // Operands are < n, so each doubling and each addition needs at most one subtract.
   always_comb begin
      nn   = {2'b00, n_q};
      dbl  = {1'b0, p_q, 1'b0};
      red1 = (dbl >= nn) ? dbl - nn : dbl;
      sum  = red1 + (a_q[W-1] ? {2'b00, b_q} : '0);
      red2 = (sum >= nn) ? sum - nn : sum;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q    <= '0;
         b_q    <= '0;
         n_q    <= '0;
         p_q    <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (!busy_q) begin
         if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            n_q    <= n_i;
            p_q    <= '0;
            cnt_q  <= CW'(W);
            busy_q <= 1'b1;
         end
      end else begin
         p_q   <= red2[W-1:0];
         a_q   <= a_q << 1;
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) busy_q <= 1'b0;
      end
   end

   assign ready_o = ~busy_q;
   assign p_o     = p_q;
endmodule

// File: rtl/modexp.sv
// Left-to-right square-and-multiply controller driving an external modmul through
// the start/ready handshake; operands stay frozen for each whole multiply.
module modexp
   import modexp_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int EW = W
) (
   input  logic     clk,
   input  logic     rst,
   modexp_if.slave  bus
);
   state_e        state_q, state_d;
   logic [W-1:0]  base_q, base_d;
   logic [W-1:0]  n_q, n_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [EW-1:0] exp_q, exp_d;
   logic [RW-1:0] rem_q, rem_d;
   logic          seen_lo_q, seen_lo_d;
   logic          sqr_phase;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         n_q       <= '0;
         acc_q     <= '0;
         exp_q     <= '0;
         rem_q     <= '0;
         seen_lo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         n_q       <= n_d;
         acc_q     <= acc_d;
         exp_q     <= exp_d;
         rem_q     <= rem_d;
         seen_lo_q <= seen_lo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      n_d       = n_q;
      acc_d     = acc_q;
      exp_d     = exp_q;
      rem_d     = rem_q;
      seen_lo_d = seen_lo_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               base_d  = bus.base;
               exp_d   = bus.exp;
               n_d     = bus.n;
               acc_d   = W'(1);
               rem_d   = RW'(EW);
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (rem_q == '0) begin
               state_d = S_IDLE;
            end else begin
               exp_d = exp_q << 1;
               rem_d = rem_q - RW'(1);
               if (exp_q[EW-1]) begin
                  acc_d   = base_q;
                  state_d = S_STEP;
               end
            end
         end
         S_STEP: begin
            state_d = (rem_q == '0) ? S_IDLE : S_SQR_ISSUE;
         end
         S_SQR_ISSUE, S_MUL_ISSUE: begin
            if (bus.mm_ready) begin
               seen_lo_d = 1'b0;
               state_d   = (state_q == S_SQR_ISSUE) ? S_SQR_WAIT : S_MUL_WAIT;
            end
         end
         S_SQR_WAIT, S_MUL_WAIT: begin
            // A ready seen before the multiplier has dropped it is the stale idle level.
            if (!bus.mm_ready) begin
               seen_lo_d = 1'b1;
            end else if (seen_lo_q) begin
               acc_d = bus.mm_p;
               if (state_q == S_SQR_WAIT && exp_q[EW-1]) begin
                  state_d = S_MUL_ISSUE;
               end else begin
                  exp_d   = exp_q << 1;
                  rem_d   = rem_q - RW'(1);
                  state_d = S_STEP;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign sqr_phase    = (state_q == S_SQR_ISSUE) || (state_q == S_SQR_WAIT);
   assign bus.ready    = (state_q == S_IDLE);
   assign bus.result   = acc_q;
   assign bus.mm_start = ((state_q == S_SQR_ISSUE) || (state_q == S_MUL_ISSUE)) && bus.mm_ready;
   assign bus.mm_a     = acc_q;
   assign bus.mm_b     = sqr_phase ? acc_q : base_q;
   assign bus.mm_n     = n_q;
endmodule
